// File: rtl/i2c_txn_buffer_pkg.sv
// Shared types and helpers for the I2C transaction buffer (package i2c_pkg).
// The optional watchdog is enabled by defining I2C_TIMEOUT_EN.
package i2c_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_RUN    = 2'd2
  } state_e;

  localparam int FIFO_DEPTH_DEF = 8;
  localparam int PTR_W = $clog2(FIFO_DEPTH_DEF);

  // Bytes the TX FIFO must hold to start: a read-only transfer reuses the
  // single control byte (bit 0 set), so it needs no separate read control byte.
  function automatic logic [8:0] req_bytes(input logic [7:0] wr_len, input logic [7:0] rd_len);
    logic [8:0] n;
    n = 9'd1 + {1'b0, wr_len};
    if ((rd_len != 8'd0) && (wr_len != 8'd0)) n = n + 9'd1;
    return n;
  endfunction

endpackage

// File: rtl/i2c_byte_fifo.sv
// Byte FIFO with extra-MSB pointers; head is combinational and reads 0 when empty.
module i2c_byte_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [7:0]               wdata,
  input  logic                     pop,
  output logic [7:0]               rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        pop_ok;
  logic        push_ok;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign level = wr_ptr_q - rd_ptr_q;
  assign rdata = empty ? 8'd0 : mem_q[rd_ptr_q[AW-1:0]];

  // A push into a full FIFO is still accepted when the head leaves in the same cycle.
  assign pop_ok  = pop & ~empty & ~flush;
  assign push_ok = push & ~flush & (~full | pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/i2c_txn_buffer.sv
// CPU-side command/data buffer feeding the I2C master.
// Define I2C_TIMEOUT_EN to add a LAUNCH/RUN watchdog of TIMEOUT_CYCLES.
module i2c_txn_buffer
  import i2c_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          cpu_tx_wr,
  input  logic [7:0]                    cpu_tx_data,
  input  logic                          cpu_rx_rd,
  output logic [7:0]                    cpu_rx_data,
  input  logic                          cpu_start,
  input  logic [7:0]                    cpu_wr_len,
  input  logic [7:0]                    cpu_rd_len,
  input  logic                          cpu_clr,
  output logic [$clog2(FIFO_DEPTH):0]   tx_level,
  output logic [$clog2(FIFO_DEPTH):0]   rx_level,
  output logic                          stat_busy,
  output logic                          stat_done,
  output logic                          stat_ack_err,
  output logic                          stat_cfg_err,
  output logic                          stat_ovf,
  output logic                          m_enable,
  output logic [7:0]                    m_write_length,
  output logic [7:0]                    m_read_length,
  output logic [7:0]                    m_tx_data,
  input  logic                          m_tx_done,
  input  logic [7:0]                    m_rx_data,
  input  logic                          m_rx_done,
  input  logic                          m_ack_err,
  input  logic                          m_busy,
  output logic [1:0]                    dbg_state
);

  state_e      state_q, state_d;
  logic        m_enable_q, m_enable_d;
  logic [7:0]  wr_len_q, wr_len_d;
  logic [7:0]  rd_len_q, rd_len_d;
  logic [8:0]  req_q, req_d;
  logic [8:0]  pop_cnt_q, pop_cnt_d;
  logic        done_q, done_d;
  logic        ack_q, ack_d;
  logic        cfg_q, cfg_d;
  logic        ovf_q, ovf_d;
  logic        tx_done_q, rx_done_q, ack_err_q, busy_q;

  logic        active, in_idle;
  logic        tx_rise, rx_rise, ack_rise, busy_fall;
  logic        tx_pop_try, tx_pop_ok, tx_push_drop, tx_pop_drop;
  logic        rx_push, rx_pop_ok, rx_push_drop;
  logic        tx_full, tx_empty, rx_full, rx_empty;
  logic        flush_all, tx_flush;
  logic        timeout_hit;
  logic [8:0]  req_now;

  assign in_idle   = (state_q == ST_IDLE);
  assign active    = ~in_idle;
  assign tx_rise   = m_tx_done & ~tx_done_q;
  assign rx_rise   = m_rx_done & ~rx_done_q;
  assign ack_rise  = m_ack_err & ~ack_err_q;
  assign busy_fall = busy_q & ~m_busy;
  assign req_now   = req_bytes(cpu_wr_len, cpu_rd_len);

  // The master raises tx_done once more than there are bytes to fetch; the
  // pop budget set at launch keeps that last edge from consuming a byte.
  assign tx_pop_try   = active & tx_rise & (pop_cnt_q < req_q);
  assign tx_pop_ok    = tx_pop_try & ~tx_empty;
  assign tx_pop_drop  = tx_pop_try & tx_empty;
  assign flush_all    = cpu_clr & in_idle;
  assign tx_flush     = flush_all | timeout_hit;
  assign tx_push_drop = cpu_tx_wr & ~tx_flush & tx_full & ~tx_pop_ok;

  assign rx_push      = (state_q == ST_RUN) & rx_rise;
  assign rx_pop_ok    = cpu_rx_rd & ~rx_empty;
  assign rx_push_drop = rx_push & rx_full & ~rx_pop_ok;

`ifdef I2C_TIMEOUT_EN
  logic [31:0] to_cnt_q, to_cnt_d;

  assign timeout_hit = active & (to_cnt_q == 32'(TIMEOUT_CYCLES - 1));

  always_comb begin
    to_cnt_d = '0;
    if (active && !timeout_hit) to_cnt_d = to_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) to_cnt_q <= '0;
    else        to_cnt_q <= to_cnt_d;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    m_enable_d = m_enable_q;
    wr_len_d   = wr_len_q;
    rd_len_d   = rd_len_q;
    req_d      = req_q;
    pop_cnt_d  = pop_cnt_q;
    done_d     = done_q;
    ack_d      = ack_q;
    cfg_d      = cfg_q;
    ovf_d      = ovf_q;

    if (cpu_clr) begin
      done_d = 1'b0;
      ack_d  = 1'b0;
      cfg_d  = 1'b0;
      ovf_d  = 1'b0;
    end

    if (tx_pop_try) pop_cnt_d = pop_cnt_q + 9'd1;

    case (state_q)
      ST_IDLE: begin
        if (cpu_start) begin
          if (9'(tx_level) >= req_now) begin
            wr_len_d   = cpu_wr_len;
            rd_len_d   = cpu_rd_len;
            req_d      = req_now;
            pop_cnt_d  = '0;
            m_enable_d = 1'b1;
            state_d    = ST_LAUNCH;
          end else begin
            cfg_d = 1'b1;
          end
        end
      end
      ST_LAUNCH: begin
        if (m_busy) begin
          m_enable_d = 1'b0;
          state_d    = ST_RUN;
        end
      end
      ST_RUN: begin
        if (busy_fall) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (timeout_hit) begin
      cfg_d      = 1'b1;
      m_enable_d = 1'b0;
      state_d    = ST_IDLE;
    end

    if (tx_pop_drop)                 cfg_d = 1'b1;
    if (ack_rise)                    ack_d = 1'b1;
    if (tx_push_drop | rx_push_drop) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      m_enable_q <= 1'b0;
      wr_len_q   <= '0;
      rd_len_q   <= '0;
      req_q      <= '0;
      pop_cnt_q  <= '0;
      done_q     <= 1'b0;
      ack_q      <= 1'b0;
      cfg_q      <= 1'b0;
      ovf_q      <= 1'b0;
      tx_done_q  <= 1'b0;
      rx_done_q  <= 1'b0;
      ack_err_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      m_enable_q <= m_enable_d;
      wr_len_q   <= wr_len_d;
      rd_len_q   <= rd_len_d;
      req_q      <= req_d;
      pop_cnt_q  <= pop_cnt_d;
      done_q     <= done_d;
      ack_q      <= ack_d;
      cfg_q      <= cfg_d;
      ovf_q      <= ovf_d;
      tx_done_q  <= m_tx_done;
      rx_done_q  <= m_rx_done;
      ack_err_q  <= m_ack_err;
      busy_q     <= m_busy;
    end
  end

  i2c_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst_n (reset),
    .flush (tx_flush),
    .push  (cpu_tx_wr),
    .wdata (cpu_tx_data),
    .pop   (tx_pop_try),
    .rdata (m_tx_data),
    .full  (tx_full),
    .empty (tx_empty),
    .level (tx_level)
  );

  i2c_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst_n (reset),
    .flush (flush_all),
    .push  (rx_push),
    .wdata (m_rx_data),
    .pop   (cpu_rx_rd),
    .rdata (cpu_rx_data),
    .full  (rx_full),
    .empty (rx_empty),
    .level (rx_level)
  );

  assign stat_busy      = active;
  assign stat_done      = done_q;
  assign stat_ack_err   = ack_q;
  assign stat_cfg_err   = cfg_q;
  assign stat_ovf       = ovf_q;
  assign m_enable       = m_enable_q;
  assign m_write_length = wr_len_q;
  assign m_read_length  = rd_len_q;
  assign dbg_state      = state_q;

endmodule

// File: doc/i2c_txn_buffer.md
Name: i2c_txn_buffer

Overview:
Upstream command/data buffer that feeds the I2C master from the CPU's register interface. Software loads byte sequences into a TX FIFO, sets the write/read lengths and pulses a start command. The block then launches the master, hands it bytes on its tx_done edges and captures received bytes into an RX FIFO on its rx_done edges. It reports completion and errors through sticky status flags.

Parameters:
- FIFO_DEPTH, 8, entries in each of the TX and RX FIFOs; power of 2, minimum 4.
- TIMEOUT_CYCLES, 2000000, transaction watchdog limit in clk cycles; used only with I2C_TIMEOUT_EN.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- cpu_tx_wr  in  1  push cpu_tx_data into TX FIFO
- cpu_tx_data  in  8  byte to push
- cpu_rx_rd  in  1  pop RX FIFO head
- cpu_rx_data  out  8  RX FIFO head; 0 when empty
- cpu_start  in  1  one-cycle start-transaction pulse
- cpu_wr_len  in  8  data bytes to write, excluding the control byte
- cpu_rd_len  in  8  bytes to read
- cpu_clr  in  1  clear sticky flags and flush both FIFOs
- tx_level  out  4  TX FIFO occupancy
- rx_level  out  4  RX FIFO occupancy
- stat_busy  out  1  high in states LAUNCH and RUN
- stat_done  out  1  sticky: transaction finished
- stat_ack_err  out  1  sticky: master reported ack_err
- stat_cfg_err  out  1  sticky: start rejected, or TX ran short mid-transaction
- stat_ovf  out  1  sticky: RX push while full, or CPU push while TX full
- m_enable  out  1  to master ENABLE
- m_write_length  out  8  latched cpu_wr_len
- m_read_length  out  8  latched cpu_rd_len
- m_tx_data  out  8  TX FIFO head
- m_tx_done  in  1  master tx_done (level)
- m_rx_data  in  8  master rx_data
- m_rx_done  in  1  master rx_done (level)
- m_ack_err  in  1  master ack_err
- m_busy  in  1  master busy

Behaviour:
- Reset (reset low, asynchronous):
  - state IDLE, both FIFOs empty, all sticky flags 0.
  - m_enable 0, m_write_length 0, m_read_length 0.
  - Edge-detect registers set to 0.
- Byte-order contract: the TX FIFO holds, in order, the write control byte, the data bytes, then the read control byte if a read is done.
- Required byte count is REQ = 1 + wr_len + (rd_len != 0 ? 1 : 0). For a read-only transaction (rd_len != 0, wr_len == 0) the first byte has bit 0 = 1 and REQ = 1.
- State machine IDLE -> LAUNCH -> RUN -> IDLE:
  - IDLE, cpu_start high:
    - If tx_level >= REQ: latch the lengths, set m_enable=1 next cycle, go to LAUNCH.
    - Otherwise: set stat_cfg_err, stay in IDLE.
  - LAUNCH: hold m_enable=1 until m_busy is seen high, then drop m_enable and go to RUN.
  - RUN: on m_busy falling edge, set stat_done and go to IDLE.
- TX pop rule: pop one entry on each rising edge of m_tx_done, except the final edge of the transaction. The master samples the head at START, RESTART and HOLD, so m_tx_data must always be the current head, combinational from the FIFO read pointer.
  - Pop count over a transaction equals REQ.
  - A pop attempted on an empty FIFO is ignored and sets stat_cfg_err.
- RX push rule: push m_rx_data on each rising edge of m_rx_done while in RUN. Push while full drops the byte and sets stat_ovf.
- m_ack_err rising edge: set stat_ack_err. The master then returns to idle itself, so stat_done is still set.
- Simultaneous events:
  - cpu_tx_wr with a pop: level unchanged.
  - cpu_rx_rd with a push: level unchanged.
  - cpu_rx_rd when empty: ignored.
  - cpu_start outside IDLE: ignored, no flag.
- cpu_clr:
  - In IDLE: flush both FIFOs and clear all sticky flags.
  - In LAUNCH or RUN: clear flags only, never flush.
- Pointers are log2(FIFO_DEPTH)+1 bits wide; full/empty are decided from the MSB difference; pointers wrap naturally.
- Latency: m_enable rises 1 cycle after cpu_start; stat_done rises 1 cycle after m_busy falls.

Optional Feature:
- I2C_TIMEOUT_EN defined:
  - A RUN/LAUNCH cycle counter runs; on reaching TIMEOUT_CYCLES it sets stat_cfg_err, drops m_enable, flushes the TX FIFO and returns to IDLE.
  - stat_done is not set on timeout.
- Undefined: no counter; the block waits indefinitely.

Decomposition:
- Package i2c_pkg holds:
  - the state enum (IDLE, LAUNCH, RUN);
  - localparam PTR_W = $clog2(FIFO_DEPTH);
  - the byte-count helper function computing REQ.
- One natural sub-module, i2c_byte_fifo (parameterised depth, push/pop/full/empty/level), instantiated twice for TX and RX.

Test Plan:
- Write 2 bytes: push 0xA0,0x10,0x55; wr_len=2, rd_len=0; start -> m_enable pulse; m_tx_data sequence 0xA0,0x10,0x55; stat_done=1; tx_level=0.
- Write-then-read: push 0xA0,0x05,0xA1; wr_len=1, rd_len=3; model returns 0x11,0x22,0x33 -> rx_level=3; CPU reads 0x11,0x22,0x33 in order; stat_done=1.
- Short TX: push 1 byte; wr_len=2; start -> stat_cfg_err=1; m_enable stays 0; state remains IDLE.
- NACK: model asserts m_ack_err after the control byte -> stat_ack_err=1 and stat_done=1; cpu_clr in IDLE -> flags 0, FIFOs empty.
- Overflow: FIFO_DEPTH=8; rd_len=9 with no CPU reads -> 8 bytes stored, stat_ovf=1, 9th byte dropped.
- Timeout (I2C_TIMEOUT_EN, TIMEOUT_CYCLES=100): m_busy held high -> stat_cfg_err at cycle 100 of RUN/LAUNCH; state IDLE; TX FIFO empty.
